modbus_frame_rx: RTL and testbench

MODBUS_FRAME_RX -- requirements
Module: modbus_frame_rx

---
 rtl/modbus_pkg.sv | 35 +++
 rtl/modbus_crc16.sv | 60 ++++++
 rtl/modbus_frame_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_modbus_frame_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared Modbus RTU definitions for the receive and response stages:
//   - rx_state_e : frame receiver state encoding
//   - T35_CHARS  : inter-frame silence in bit times (3.5 chars x 11 bits = 39)
//   - FRAME_LEN  : fixed request length handled by this slave (8 bytes)
//   - CRC_INIT / CRC_POLY : Modbus CRC-16 seed and reflected polynomial
//   - crc16_step : one bit-serial CRC-16 update
// -----------------------------------------------------------------------------
package modbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_e;

    localparam int          T35_CHARS = 39;
    localparam int          FRAME_LEN = 8;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'hA001;

    // One LSB-first shift of the reflected CRC-16 register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        if (crc[0]) begin
            crc16_step = shifted ^ CRC_POLY;
        end else begin
            crc16_step = shifted;
        end
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// -----------------------------------------------------------------------------
// modbus_crc16
// Bit-serial Modbus CRC-16 engine. A start strobe XORs the byte into the
// register (seeded with CRC_INIT when init is also high) and the following
// 8 clocks shift it one bit per clock.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   init        : with start, restart the CRC from CRC_INIT
//   start       : one-cycle strobe, absorb byte_data
//   byte_data   : byte to absorb
//   busy        : high while bits of the last byte are still being shifted
//   crc         : current CRC register
// -----------------------------------------------------------------------------
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        start,
    input  logic [7:0]  byte_data,
    output logic        busy,
    output logic [15:0] crc
);

    logic [15:0] crc_r;
    logic [3:0]  bit_cnt_r;
    logic [15:0] seed_s;

    // Seed selection: fresh CRC on init, otherwise continue the running value.
    always_comb begin
        seed_s = crc_r;
        if (init) begin
            seed_s = CRC_INIT;
        end else begin
            seed_s = crc_r;
        end
    end

    // CRC register and remaining-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r     <= CRC_INIT;
            bit_cnt_r <= 4'd0;
        end else if (start) begin
            crc_r     <= seed_s ^ {8'h00, byte_data};
            bit_cnt_r <= 4'd8;
        end else if (bit_cnt_r != 4'd0) begin
            crc_r     <= crc16_step(crc_r);
            bit_cnt_r <= bit_cnt_r - 4'd1;
        end else begin
            crc_r     <= crc_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign busy = (bit_cnt_r != 4'd0);
    assign crc  = crc_r;

endmodule

// File: rtl/modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// modbus_frame_rx
// Modbus RTU request framer. Collects bytes from a UART receiver, closes the
// frame after 3.5 character times of line silence, and checks length, slave
// address and CRC-16. An accepted 8-byte request pulses frame_valid with the
// decoded fields; an addressed request with a bad CRC pulses crc_err.
// Everything else (wrong length, other slave, overlength) is dropped silently.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   rx_done, rx_data : byte strobe and byte from the UART receiver
//   dev_addr         : this slave's address
//   frame_valid      : one-cycle pulse, fields below are valid
//   func_code        : function code of the accepted frame
//   reg_addr         : start register (bytes 2/3, big endian)
//   reg_data         : bytes 4/5 (quantity for 0x03, value for 0x06)
//   crc_err          : one-cycle pulse, addressed frame failed CRC
//   busy             : high from the first byte until the frame is closed
// -----------------------------------------------------------------------------
module modbus_frame_rx
    import modbus_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  dev_addr,
    output logic        frame_valid,
    output logic [7:0]  func_code,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_data,
    output logic        crc_err,
    output logic        busy
);

    localparam int BPS_PARAM = CLK_FREQ / BAUD_RATE;
    localparam int T35_CNT   = T35_CHARS * BPS_PARAM;
    localparam int SIL_NEED  = $clog2(T35_CNT + 1);
    localparam int SIL_W     = (SIL_NEED > 22) ? SIL_NEED : 22;

    localparam logic [SIL_W-1:0] T35_LIM     = SIL_W'(T35_CNT);
    localparam logic [3:0]       FRAME_LEN_C = 4'(FRAME_LEN);
    // Only bytes 0..5 carry fields; bytes 6/7 are the CRC and only feed the engine.
    localparam logic [3:0]       HDR_LEN_C   = 4'd6;

    rx_state_e        state_r;
    rx_state_e        state_s;
    logic [3:0]       count_r;
    logic [3:0]       count_s;
    logic [7:0]       hdr_r [0:5];
    logic             hdr_we_s;
    logic [2:0]       hdr_idx_s;
    logic [SIL_W-1:0] sil_cnt_r;
    logic             silence_s;
    logic             counting_s;

    logic             crc_start_s;
    logic             crc_init_s;
    logic             crc_busy_s;
    logic [15:0]      crc_val_s;

    logic             addressed_s;
    logic             frame_valid_s;
    logic             crc_err_s;
    logic             busy_s;

    logic             frame_valid_r;
    logic             crc_err_r;
    logic             busy_r;
    logic [7:0]       func_code_r;
    logic [15:0]      reg_addr_r;
    logic [15:0]      reg_data_r;

    modbus_crc16 u_crc (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .init      (crc_init_s),
        .start     (crc_start_s),
        .byte_data (rx_data),
        .busy      (crc_busy_s),
        .crc       (crc_val_s)
    );

    assign silence_s  = (sil_cnt_r == T35_LIM);
    assign counting_s = (state_r == ST_RECV) || (state_r == ST_DISCARD);

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a byte landing in CHECK opens the next frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_done) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rx_done) begin
                    if (count_r == FRAME_LEN_C) begin
                        state_s = ST_DISCARD;
                    end else begin
                        state_s = ST_RECV;
                    end
                end else if (silence_s && !crc_busy_s) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (rx_done) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (silence_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: byte capture, CRC control and next values of the pulses.
    always_comb begin
        crc_start_s   = 1'b0;
        crc_init_s    = 1'b0;
        hdr_we_s      = 1'b0;
        hdr_idx_s     = 3'd0;
        count_s       = count_r;
        addressed_s   = (count_r == FRAME_LEN_C) && (hdr_r[0] == dev_addr);
        frame_valid_s = 1'b0;
        crc_err_s     = 1'b0;
        busy_s        = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE, ST_CHECK: begin
                if (rx_done) begin
                    crc_start_s = 1'b1;
                    crc_init_s  = 1'b1;
                    hdr_we_s    = 1'b1;
                    hdr_idx_s   = 3'd0;
                    count_s     = 4'd1;
                end else begin
                    count_s     = count_r;
                end
                if ((state_r == ST_CHECK) && addressed_s) begin
                    frame_valid_s = (crc_val_s == 16'h0000);
                    crc_err_s     = (crc_val_s != 16'h0000);
                end else begin
                    frame_valid_s = 1'b0;
                    crc_err_s     = 1'b0;
                end
            end
            ST_RECV: begin
                if (rx_done && (count_r < FRAME_LEN_C)) begin
                    crc_start_s = 1'b1;
                    hdr_we_s    = (count_r < HDR_LEN_C);
                    hdr_idx_s   = count_r[2:0];
                    count_s     = count_r + 4'd1;
                end else begin
                    count_s     = count_r;
                end
            end
            ST_DISCARD: begin
                count_s = count_r;
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Byte count and header byte storage.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_r <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                hdr_r[i] <= 8'h00;
            end
        end else begin
            count_r <= count_s;
            if (hdr_we_s) begin
                hdr_r[hdr_idx_s] <= rx_data;
            end else begin
                hdr_r[hdr_idx_s] <= hdr_r[hdr_idx_s];
            end
        end
    end

    // Line-silence counter: restarts on every byte, saturates at 3.5 chars.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sil_cnt_r <= '0;
        end else if (rx_done) begin
            sil_cnt_r <= '0;
        end else if (counting_s && !silence_s) begin
            sil_cnt_r <= sil_cnt_r + {{(SIL_W-1){1'b0}}, 1'b1};
        end else begin
            sil_cnt_r <= sil_cnt_r;
        end
    end

    // Registered outputs; fields only move together with frame_valid.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_valid_r <= 1'b0;
            crc_err_r     <= 1'b0;
            busy_r        <= 1'b0;
            func_code_r   <= 8'h00;
            reg_addr_r    <= 16'h0000;
            reg_data_r    <= 16'h0000;
        end else begin
            frame_valid_r <= frame_valid_s;
            crc_err_r     <= crc_err_s;
            busy_r        <= busy_s;
            if (frame_valid_s) begin
                func_code_r <= hdr_r[1];
                reg_addr_r  <= {hdr_r[2], hdr_r[3]};
                reg_data_r  <= {hdr_r[4], hdr_r[5]};
            end else begin
                func_code_r <= func_code_r;
                reg_addr_r  <= reg_addr_r;
                reg_data_r  <= reg_data_r;
            end
        end
    end

    assign frame_valid = frame_valid_r;
    assign crc_err     = crc_err_r;
    assign busy        = busy_r;
    assign func_code   = func_code_r;
    assign reg_addr    = reg_addr_r;
    assign reg_data    = reg_data_r;

endmodule

// File: tb/tb_modbus_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_modbus_frame_rx
// Directed bench for modbus_frame_rx. Runs at CLK_FREQ=1 MHz, BAUD_RATE=100k:
// one bit = 10 clocks, one character = 110 clocks, 3.5 chars = 390 clocks.
// -----------------------------------------------------------------------------
module tb_modbus_frame_rx;

    localparam int CHAR  = 110;
    localparam int CLOSE = 600;

    logic        clk_in;
    logic        rst_n_in;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [7:0]  dev_addr;
    logic        frame_valid;
    logic [7:0]  func_code;
    logic [15:0] reg_addr;
    logic [15:0] reg_data;
    logic        crc_err;
    logic        busy;

    int n_cmp;
    int n_fail;
    int cyc;
    int fv_total;
    int ce_total;
    int both_total;
    int fv_cyc;
    int last_byte_cyc;

    logic [7:0] frm [0:8];

    modbus_frame_rx #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (100000)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .dev_addr    (dev_addr),
        .frame_valid (frame_valid),
        .func_code   (func_code),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .crc_err     (crc_err),
        .busy        (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (frame_valid) begin
            fv_total <= fv_total + 1;
            fv_cyc   <= cyc;
        end
        if (crc_err) ce_total <= ce_total + 1;
        if (frame_valid && crc_err) both_total <= both_total + 1;
    end

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = {1'b0, r[15:1]} ^ 16'hA001;
            else      r = {1'b0, r[15:1]};
        end
        return r;
    endfunction

    task automatic set_frame(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) frm[i] = bytes[63-8*i -: 8];
        frm[8] = 8'h55;
    endtask

    // Replace bytes 6/7 with the correct CRC of bytes 0..5 (low byte first).
    task automatic fix_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 6; i++) c = crc_byte(c, frm[i]);
        frm[6] = c[7:0];
        frm[7] = c[15:8];
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_in);
        rx_data       = b;
        rx_done       = 1'b1;
        last_byte_cyc = cyc + 1;
        @(negedge clk_in);
        rx_done = 1'b0;
        repeat (gap - 1) @(negedge clk_in);
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(frm[i], CHAR);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        dev_addr = 8'h01;
        repeat (3) @(negedge clk_in);
        n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        n_cmp++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err: got %b want 0", crc_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (func_code !== 8'h00) begin n_fail++; $display("FAIL reset_func_code: got %h want 00", func_code); end
        n_cmp++; if (reg_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_reg_addr: got %h want 0000", reg_addr); end
        n_cmp++; if (reg_data !== 16'h0000) begin n_fail++; $display("FAIL reset_reg_data: got %h want 0000", reg_data); end
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_valid_frame();
        int fv0, ce0, lat;
        fv0 = fv_total; ce0 = ce_total;
        set_frame(64'h01_03_00_00_00_01_84_0A);
        send_byte(frm[0], CHAR);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL valid_busy_mid: got %b want 1", busy); end
        for (int i = 1; i < 8; i++) send_byte(frm[i], CHAR);
        n_cmp++; if (fv_total != fv0) begin n_fail++; $display("FAIL valid_early_pulse: got %0d want 0", fv_total - fv0); end
        repeat (CLOSE) @(negedge clk_in);
        lat = fv_cyc - last_byte_cyc;
        n_cmp++; if (fv_total - fv0 != 1) begin n_fail++; $display("FAIL valid_fv_count: got %0d want 1", fv_total - fv0); end
        n_cmp++; if (ce_total - ce0 != 0) begin n_fail++; $display("FAIL valid_ce_count: got %0d want 0", ce_total - ce0); end
        n_cmp++; if (lat < 385 || lat > 400) begin n_fail++; $display("FAIL valid_latency: got %0d want 385..400", lat); end
        n_cmp++; if (func_code !== 8'h03) begin n_fail++; $display("FAIL valid_func_code: got %h want 03", func_code); end
        n_cmp++; if (reg_addr !== 16'h0000) begin n_fail++; $display("FAIL valid_reg_addr: got %h want 0000", reg_addr); end
        n_cmp++; if (reg_data !== 16'h0001) begin n_fail++; $display("FAIL valid_reg_data: got %h want 0001", reg_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL valid_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_write_frame();
        int fv0;
        fv0 = fv_total;
        set_frame(64'h01_06_00_01_12_34_00_00);
        fix_crc();
        send_frame(8);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if (fv_total - fv0 != 1) begin n_fail++; $display("FAIL write_fv_count: got %0d want 1", fv_total - fv0); end
        n_cmp++; if (func_code !== 8'h06) begin n_fail++; $display("FAIL write_func_code: got %h want 06", func_code); end
        n_cmp++; if (reg_addr !== 16'h0001) begin n_fail++; $display("FAIL write_reg_addr: got %h want 0001", reg_addr); end
        n_cmp++; if (reg_data !== 16'h1234) begin n_fail++; $display("FAIL write_reg_data: got %h want 1234", reg_data); end
    endtask

    task automatic test_crc_error();
        int fv0, ce0;
        fv0 = fv_total; ce0 = ce_total;
        set_frame(64'h01_03_00_00_00_01_84_0B);
        send_frame(8);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if (ce_total - ce0 != 1) begin n_fail++; $display("FAIL crcerr_ce_count: got %0d want 1", ce_total - ce0); end
        n_cmp++; if (fv_total - fv0 != 0) begin n_fail++; $display("FAIL crcerr_fv_count: got %0d want 0", fv_total - fv0); end
        n_cmp++; if (func_code !== 8'h06) begin n_fail++; $display("FAIL crcerr_hold_func: got %h want 06", func_code); end
        n_cmp++; if (reg_addr !== 16'h0001) begin n_fail++; $display("FAIL crcerr_hold_addr: got %h want 0001", reg_addr); end
        n_cmp++; if (reg_data !== 16'h1234) begin n_fail++; $display("FAIL crcerr_hold_data: got %h want 1234", reg_data); end
    endtask

    task automatic test_addr_mismatch();
        int fv0, ce0;
        fv0 = fv_total; ce0 = ce_total;
        dev_addr = 8'h02;
        set_frame(64'h01_03_00_00_00_01_84_0A);
        send_frame(4);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL addr_busy_mid: got %b want 1", busy); end
        for (int i = 4; i < 8; i++) send_byte(frm[i], CHAR);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if ((fv_total - fv0) + (ce_total - ce0) != 0) begin n_fail++; $display("FAIL addr_pulses: got %0d want 0", (fv_total - fv0) + (ce_total - ce0)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL addr_busy_end: got %b want 0", busy); end
        dev_addr = 8'h01;
    endtask

    task automatic test_overlength();
        int fv0, ce0;
        fv0 = fv_total; ce0 = ce_total;
        set_frame(64'h01_03_00_00_00_01_84_0A);
        send_frame(9);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if ((fv_total - fv0) + (ce_total - ce0) != 0) begin n_fail++; $display("FAIL overlen_pulses: got %0d want 0", (fv_total - fv0) + (ce_total - ce0)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overlen_busy_end: got %b want 0", busy); end
        send_frame(8);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if (fv_total - fv0 != 1) begin n_fail++; $display("FAIL overlen_next_fv: got %0d want 1", fv_total - fv0); end
    endtask

    task automatic test_gaps();
        int fv0, ce0;
        fv0 = fv_total; ce0 = ce_total;
        set_frame(64'h01_03_00_00_00_01_84_0A);
        for (int i = 0; i < 8; i++) send_byte(frm[i], (i == 3) ? 2 * CHAR : CHAR);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if (fv_total - fv0 != 1) begin n_fail++; $display("FAIL gap2_fv_count: got %0d want 1", fv_total - fv0); end
        fv0 = fv_total;
        for (int i = 0; i < 5; i++) send_byte(frm[i], (i == 4) ? 4 * CHAR : CHAR);
        n_cmp++; if ((fv_total - fv0) + (ce_total - ce0) != 0) begin n_fail++; $display("FAIL gap4_pulses: got %0d want 0", (fv_total - fv0) + (ce_total - ce0)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap4_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int fv0, ce0;
        fv0 = fv_total; ce0 = ce_total;
        set_frame(64'h01_03_00_00_00_01_84_0A);
        send_frame(4);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (func_code !== 8'h00) begin n_fail++; $display("FAIL rstmid_func_code: got %h want 00", func_code); end
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        send_frame(8);
        repeat (CLOSE) @(negedge clk_in);
        n_cmp++; if (fv_total - fv0 != 1) begin n_fail++; $display("FAIL rstmid_fv_count: got %0d want 1", fv_total - fv0); end
        n_cmp++; if (ce_total - ce0 != 0) begin n_fail++; $display("FAIL rstmid_ce_count: got %0d want 0", ce_total - ce0); end
        n_cmp++; if (func_code !== 8'h03) begin n_fail++; $display("FAIL rstmid_func_after: got %h want 03", func_code); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        cyc = 0; fv_total = 0; ce_total = 0; both_total = 0;
        fv_cyc = 0; last_byte_cyc = 0;
        test_reset();
        test_valid_frame();
        test_write_frame();
        test_crc_error();
        test_addr_mismatch();
        test_overlength();
        test_gaps();
        test_reset_mid();
        n_cmp++; if (both_total != 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d want 0", both_total); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
